// File: rtl/dcm_rst_seq_if.sv
// Status/control bundle between the reset sequencer and the clock-manager chain.
// Latency: none (wires only).
// Backpressure: none; level signals only.
interface dcm_rst_seq_if #(
    parameter int N_STAGES  = 2,
    parameter int MAX_RETRY = 3
);
    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic                user_rst;
    logic [N_STAGES-1:0] dcm_locked;
    logic [N_STAGES-1:0] dcm_rst;
    logic                all_locked;
    logic                fault;
    logic [SW-1:0]       stage;
    logic [RW-1:0]       retry_cnt;

    modport master (
        output user_rst, dcm_locked,
        input  dcm_rst, all_locked, fault, stage, retry_cnt
    );

    modport slave (
        input  user_rst, dcm_locked,
        output dcm_rst, all_locked, fault, stage, retry_cnt
    );
endinterface

// File: rtl/dcm_rst_seq.sv
// Brings a chain of cascaded DCM/PLLs out of reset in order, with lock timeout, bounded retry and sticky fault.
// Latency: lock input to decision is 2 synchroniser cycles plus 1 FSM cycle; all outputs registered.
// Backpressure: none; the clock managers are driven by level resets only.
module dcm_rst_seq #(
    parameter int N_STAGES     = 2,
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic          bus_clk,
    input  logic          bus_rst_n,
    dcm_rst_seq_if.slave  bus
);
    localparam int SW   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int RW   = $clog2(MAX_RETRY + 1);
    localparam int CMAX = (RST_CYCLES > LOCK_TIMEOUT)
                        ? ((RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE)
                        : ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE);
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [SW-1:0]       stage;
    logic [SW-1:0]       stage_inc;
    logic [RW-1:0]       retry;
    logic [N_STAGES-1:0] sync1;
    logic [N_STAGES-1:0] lk;
    logic [N_STAGES-1:0] dcm_rst_q;
    logic                all_locked_q;
    logic                fault_q;
    logic [SW-1:0]       low_idx;
    logic                any_low;
    logic                up_loss;
    logic                lk_cur;

    // Reset pattern seen by the chain for a given state/stage: downstream always held,
    // the active stage held only while its reset pulse is running.
    function automatic logic [N_STAGES-1:0] rst_vec(input state_t s, input logic [SW-1:0] stg);
        logic [N_STAGES-1:0] v;
        v = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            v[i] = (i > int'(stg)) || ((i == int'(stg)) && (s == S_RESET));
        end
        return v;
    endfunction

    // User restart deliberately leaves the synchronisers alone.
    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            sync1 <= '0;
            lk    <= '0;
        end else begin
            sync1 <= bus.dcm_locked;
            lk    <= sync1;
        end
    end

    always_comb begin
        low_idx = '0;
        any_low = 1'b0;
        for (int j = N_STAGES - 1; j >= 0; j--) begin
            if (!lk[j]) begin
                low_idx = SW'(j);
                any_low = 1'b1;
            end
        end
    end

    assign up_loss   = any_low && (low_idx < stage);
    assign lk_cur    = lk[stage];
    assign stage_inc = stage + SW'(1);

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n || bus.user_rst) begin
            state        <= S_RESET;
            cnt          <= '0;
            stage        <= '0;
            retry        <= '0;
            dcm_rst_q    <= '1;
            all_locked_q <= 1'b0;
            fault_q      <= 1'b0;
        end else if ((state == S_RUN && any_low) ||
                     ((state == S_RESET || state == S_WAIT || state == S_STABLE) && up_loss)) begin
            state        <= S_RESET;
            cnt          <= '0;
            stage        <= low_idx;
            retry        <= '0;
            dcm_rst_q    <= rst_vec(S_RESET, low_idx);
            all_locked_q <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        state     <= S_WAIT;
                        cnt       <= '0;
                        dcm_rst_q <= rst_vec(S_WAIT, stage);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (lk_cur) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        cnt   <= '0;
                        retry <= retry + RW'(1);
                        if (retry == RW'(MAX_RETRY - 1)) begin
                            state     <= S_FAULT;
                            fault_q   <= 1'b1;
                            dcm_rst_q <= '1;
                        end else begin
                            state     <= S_RESET;
                            dcm_rst_q <= rst_vec(S_RESET, stage);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STABLE: begin
                    // A glitch restarts the lock wait but keeps the retry budget already spent.
                    if (!lk_cur) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_STABLE - 1)) begin
                        cnt   <= '0;
                        retry <= '0;
                        if (stage == SW'(N_STAGES - 1)) begin
                            state        <= S_RUN;
                            all_locked_q <= 1'b1;
                        end else begin
                            state     <= S_RESET;
                            stage     <= stage_inc;
                            dcm_rst_q <= rst_vec(S_RESET, stage_inc);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN, S_FAULT: ;
                default: begin
                    state     <= S_RESET;
                    cnt       <= '0;
                    dcm_rst_q <= '1;
                end
            endcase
        end
    end

    assign bus.dcm_rst    = dcm_rst_q;
    assign bus.all_locked = all_locked_q;
    assign bus.fault      = fault_q;
    assign bus.stage      = stage;
    assign bus.retry_cnt  = retry;
endmodule

// File: tb/tb_dcm_rst_seq.sv
// Bench for dcm_rst_seq: clock-manager models react to DCM_RST; a phase/elapsed-time model predicts every output each cycle.
// Directed scenarios add cycle-exact literal expectations on top of the model.
module tb_dcm_rst_seq;
    localparam int NS = 3, RC = 4, LT = 64, LS = 8, MR = 2, LOCK_DLY = 20;
    localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcm_rst_seq_if #(.N_STAGES(NS), .MAX_RETRY(MR)) bus ();

    dcm_rst_seq #(
        .N_STAGES(NS), .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRY(MR)
    ) dut (
        .bus_clk(clk),
        .bus_rst_n(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [NS-1:0] m_s1 = '0, m_lk = '0;
    int m_phase = P_RESET, m_stage = 0, m_retry = 0, m_time = 0;

    int            pll_cnt  [NS];
    int            pll_fail [NS];
    bit            pll_dead [NS];
    logic [NS-1:0] prev_rst  = '1;
    logic [NS-1:0] force_low = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic enter(input int ph, input int stg);
        m_phase = ph;
        m_stage = stg;
        m_time  = 0;
    endtask

    // Spec-level model: which stage is being handled, what phase it is in, and how long it has been there.
    task automatic model_edge();
        logic [NS-1:0] seen;
        int low;
        seen = m_lk;
        if (!rst_n) begin
            m_s1 = '0;
            m_lk = '0;
        end else begin
            m_lk = m_s1;
            m_s1 = bus.dcm_locked;
        end
        low = NS;
        for (int j = NS - 1; j >= 0; j--) if (!seen[j]) low = j;
        if (!rst_n || bus.user_rst) begin
            enter(P_RESET, 0);
            m_retry = 0;
        end else if ((m_phase == P_RUN && low < NS) ||
                     (m_phase != P_RUN && m_phase != P_FAULT && low < m_stage)) begin
            enter(P_RESET, low);
            m_retry = 0;
        end else begin
            m_time++;
            case (m_phase)
                P_RESET: if (m_time == RC) enter(P_WAIT, m_stage);
                P_WAIT: begin
                    if (seen[m_stage]) enter(P_STABLE, m_stage);
                    else if (m_time == LT) begin
                        m_retry++;
                        enter((m_retry == MR) ? P_FAULT : P_RESET, m_stage);
                    end
                end
                P_STABLE: begin
                    if (!seen[m_stage]) enter(P_WAIT, m_stage);
                    else if (m_time == LS) begin
                        m_retry = 0;
                        if (m_stage == NS - 1) enter(P_RUN, m_stage);
                        else enter(P_RESET, m_stage + 1);
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Clock-manager model: locks LOCK_DLY cycles after its reset falls, unless told to fail that attempt.
    task automatic pll_update();
        logic [NS-1:0] v;
        v = '0;
        for (int i = 0; i < NS; i++) begin
            if (bus.dcm_rst[i]) begin
                pll_cnt[i] = 0;
            end else begin
                if (prev_rst[i]) begin
                    pll_dead[i] = (pll_fail[i] > 0);
                    if (pll_fail[i] > 0) pll_fail[i]--;
                end
                if (pll_cnt[i] < LOCK_DLY) pll_cnt[i]++;
            end
            v[i] = !bus.dcm_rst[i] && !pll_dead[i] && (pll_cnt[i] >= LOCK_DLY);
        end
        prev_rst       = bus.dcm_rst;
        bus.dcm_locked = v & ~force_low;
        force_low      = '0;
    endtask

    task automatic step();
        logic [NS-1:0] exp_rst;
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        for (int i = 0; i < NS; i++)
            exp_rst[i] = (m_phase == P_FAULT) || (i > m_stage) || (i == m_stage && m_phase == P_RESET);
        check("model_dcm_rst",    bus.dcm_rst,    exp_rst);
        check("model_all_locked", bus.all_locked, m_phase == P_RUN);
        check("model_fault",      bus.fault,      m_phase == P_FAULT);
        check("model_stage",      bus.stage,      m_stage);
        check("model_retry_cnt",  bus.retry_cnt,  m_retry);
        pll_update();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.user_rst = 1'b0;
        force_low    = '0;
        for (int i = 0; i < NS; i++) begin
            pll_fail[i] = 0;
            pll_dead[i] = 1'b0;
            pll_cnt[i]  = 0;
        end
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wait_all_locked(input string name, input int budget);
        int n;
        n = 0;
        while (!bus.all_locked && n < budget) begin
            step();
            n++;
        end
        check(name, bus.all_locked, 1);
    endtask

    initial begin
        bus.user_rst   = 1'b0;
        bus.dcm_locked = '0;

        // Nominal bring-up, then a 1-cycle lock drop on stage 1 while running.
        do_reset();
        check("rst_dcm_rst", bus.dcm_rst, 3'b111);
        check("rst_all_locked", bus.all_locked, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_stage", bus.stage, 0);
        check("rst_retry", bus.retry_cnt, 0);
        run_to(3);   check("nom_rst0_hold", bus.dcm_rst, 3'b111);
        run_to(4);   check("nom_rst0_fall", bus.dcm_rst, 3'b110);
        run_to(37);  check("nom_rst1_hold", bus.dcm_rst, 3'b110);
        run_to(38);  check("nom_rst1_fall", bus.dcm_rst, 3'b100);
        run_to(101); check("nom_al_pre", bus.all_locked, 0);
        run_to(102); check("nom_al", bus.all_locked, 1);
        check("nom_stage", bus.stage, 2);
        check("nom_retry", bus.retry_cnt, 0);
        check("nom_dcm_rst", bus.dcm_rst, 3'b000);
        run_to(109); force_low[1] = 1'b1;
        run_to(112); check("loss_al_hold", bus.all_locked, 1);
        run_to(113); check("loss_al_fall", bus.all_locked, 0);
        check("loss_stage", bus.stage, 1);
        check("loss_dcm_rst", bus.dcm_rst, 3'b110);
        run_to(116); check("loss_rst_hold", bus.dcm_rst, 3'b110);
        run_to(117); check("loss_rst_fall", bus.dcm_rst, 3'b100);
        wait_all_locked("loss_recover", 300);

        // Stage 1 misses its first lock window.
        do_reset();
        pll_fail[1] = 1;
        run_to(101); check("retry_pre_cnt", bus.retry_cnt, 0);
        check("retry_pre_rst", bus.dcm_rst, 3'b100);
        run_to(102); check("retry_cnt1", bus.retry_cnt, 1);
        check("retry_rst_rise", bus.dcm_rst, 3'b110);
        run_to(105); check("retry_rst_hold", bus.dcm_rst, 3'b110);
        run_to(106); check("retry_rst_fall", bus.dcm_rst, 3'b100);
        run_to(135); check("retry_cnt_kept", bus.retry_cnt, 1);
        run_to(136); check("retry_cnt_clr", bus.retry_cnt, 0);
        check("retry_stage2", bus.stage, 2);
        wait_all_locked("retry_al", 300);

        // Stage 1 never locks: fault, then user restart.
        do_reset();
        pll_fail[1] = 2;
        run_to(169); check("fault_pre", bus.fault, 0);
        run_to(170); check("fault_set", bus.fault, 1);
        check("fault_stage", bus.stage, 1);
        check("fault_retry", bus.retry_cnt, 2);
        check("fault_dcm_rst", bus.dcm_rst, 3'b111);
        run_to(180); check("fault_sticky", bus.fault, 1);
        bus.user_rst = 1'b1;
        step();
        bus.user_rst = 1'b0;
        check("urst_fault", bus.fault, 0);
        check("urst_stage", bus.stage, 0);
        check("urst_dcm_rst", bus.dcm_rst, 3'b111);
        wait_all_locked("urst_al", 300);

        // Upstream loss landing on the same cycle stage 2 finishes its stable count.
        do_reset();
        run_to(98); force_low[0] = 1'b1;
        run_to(101); check("up_pre_stage", bus.stage, 2);
        run_to(102); check("up_stage", bus.stage, 0);
        check("up_dcm_rst", bus.dcm_rst, 3'b111);
        check("up_al", bus.all_locked, 0);
        run_to(105); check("up_rst_hold", bus.dcm_rst, 3'b111);
        run_to(106); check("up_rst_fall", bus.dcm_rst, 3'b110);
        wait_all_locked("up_al_recover", 300);

        // Bus reset while stage 2 waits for lock.
        do_reset();
        run_to(79); check("mid_pre_stage", bus.stage, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_dcm_rst", bus.dcm_rst, 3'b111);
        check("mid_al", bus.all_locked, 0);
        check("mid_fault", bus.fault, 0);
        check("mid_stage", bus.stage, 0);
        check("mid_retry", bus.retry_cnt, 0);
        wait_all_locked("mid_al_recover", 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcm_rst_seq.md
# dcm_rst_seq

Parametrised reset/lock sequencer for a chain of N_STAGES cascaded clock managers (DCM/PLL), each fed by the previous one. It drives each stage's RST input and brings the stages up strictly in order. A stage is released only after every upstream stage has been locked and stable. Lock loss, lock timeout with bounded retry, and a sticky fault are all handled. The block runs in the always-present bus clock domain next to the clock generator and replaces ad-hoc flip-flop/OR reset pulse chains.

## Interface
- N_STAGES, 2: number of cascaded clock managers (1..8); stage 0 is upstream.
- RST_CYCLES, 4: clock-manager reset pulse length in BUS_CLK cycles (≥3).
- LOCK_TIMEOUT, 4096: maximum cycles to wait for lock after reset release.
- LOCK_STABLE, 16: consecutive synchronised-locked cycles required before a stage counts as up.
- MAX_RETRY, 3: reset attempts allowed per stage before FAULT (≥1).

- BUS_CLK  in  1  sequencer clock; must not be derived from any sequenced stage.
- BUS_RST_N  in  1  synchronous, active-low reset.
- USER_RST  in  1  synchronous, active-high restart request.
- DCM_LOCKED  in  N_STAGES  raw LOCKED outputs; asynchronous to BUS_CLK.
- DCM_RST  out  N_STAGES  active-high reset to each clock manager.
- ALL_LOCKED  out  1  all stages up and stable.
- FAULT  out  1  sticky; a stage exhausted MAX_RETRY.
- STAGE  out  max(1,clog2(N_STAGES))  index of the stage being sequenced or that faulted.
- RETRY_CNT  out  clog2(MAX_RETRY+1)  timeouts so far on the current stage.

## Operation
- Each DCM_LOCKED bit passes through its own 2-FF synchroniser, giving lk[i]. All decisions use lk only.
- One FSM with a shared down/up counter sized for max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE).
- DCM_RST[i] = 1 for every i > STAGE in all states, and for every i in FAULT.
- RESET: DCM_RST[STAGE] = 1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK: DCM_RST[STAGE] = 0.
  - If lk[STAGE] = 1, go to STABLE with the counter cleared.
  - If the counter reaches LOCK_TIMEOUT first, increment RETRY_CNT.
  - If RETRY_CNT then equals MAX_RETRY, go to FAULT; otherwise go to RESET.
- STABLE: count cycles while lk[STAGE] = 1.
  - If lk[STAGE] drops, return to WAIT_LOCK; the counter restarts and the timeout is not reset.
  - After LOCK_STABLE consecutive cycles: RETRY_CNT ← 0.
  - Then, if STAGE = N_STAGES−1, go to RUN; otherwise STAGE+1 and go to RESET.
- RUN: ALL_LOCKED = 1. If any lk[j] = 0, set STAGE = lowest such j, clear RETRY_CNT, and go to RESET. ALL_LOCKED falls in the same cycle the state leaves RUN.
- Upstream loss: in RESET, WAIT_LOCK or STABLE, if lk[j] = 0 for some j < STAGE, set STAGE = lowest such j, clear RETRY_CNT, and go to RESET. This has priority over the stage's own timeout or stable events in the same cycle.
- FAULT: FAULT = 1 and all DCM_RST = 1. STAGE and RETRY_CNT hold the faulting values. The FSM leaves FAULT only on BUS_RST_N = 0 or USER_RST = 1.
- USER_RST = 1: identical to reset, except that it does not re-initialise the synchronisers.

## Timing
- Reset values (BUS_RST_N = 0 at a clock edge):
  - DCM_RST = all ones.
  - ALL_LOCKED = 0, FAULT = 0, STAGE = 0, RETRY_CNT = 0.
  - State RESET, counter = 0, synchronisers = 0.
- Priority: BUS_RST_N > USER_RST > upstream loss > stage events.
- First cycle after BUS_RST_N rises: DCM_RST[0] stays 1 for RST_CYCLES cycles, then falls.
- Lock response: DCM_LOCKED[STAGE] rising → lk 2 cycles later → STABLE entry. The next stage's DCM_RST falls 2 + LOCK_STABLE + RST_CYCLES cycles after DCM_LOCKED rises (±1 for the FSM register).
- Lock-loss response: DCM_LOCKED falling in RUN → DCM_RST[lost stage and all downstream] = 1 and ALL_LOCKED = 0 within 3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Common parameters: N_STAGES = 3, RST_CYCLES = 4, LOCK_TIMEOUT = 64, LOCK_STABLE = 8, MAX_RETRY = 2.

- Nominal bring-up: the model asserts DCM_LOCKED[i] 20 cycles after DCM_RST[i] falls.
  - Required: DCM_RST pulses are 4 cycles long.
  - Required: DCM_RST[1] stays high until 2 + 8 + 4 cycles after DCM_LOCKED[0] rises.
  - Required: ALL_LOCKED = 1 after stage 2 is stable; STAGE = 2; RETRY_CNT = 0.
- Timeout retry then success: stage 1 fails to lock once, then locks.
  - Required: after 64 cycles, RETRY_CNT = 1 and DCM_RST[1] re-pulses for 4 cycles.
  - Required: RETRY_CNT = 0 after stage 1 is stable; ALL_LOCKED = 1 eventually.
- Fault: stage 1 never locks.
  - Required: FAULT = 1 after the 2nd timeout; STAGE = 1; RETRY_CNT = 2; DCM_RST = 3'b111.
  - Required: a 1-cycle USER_RST clears FAULT and restarts at stage 0.
- Lock loss in RUN: drop DCM_LOCKED[1] for 1 cycle.
  - Required: ALL_LOCKED falls within 3 cycles; DCM_RST = 3'b110 for 4 cycles; STAGE = 1.
  - Required: the sequence resumes and ALL_LOCKED returns.
- Upstream loss mid-sequence: drop DCM_LOCKED[0] while stage 2 is in STABLE.
  - Required: STAGE = 0 and DCM_RST = 3'b111 for 4 cycles.
  - Required: this holds even if stage 2's stable count completes in the same cycle.
- Reset mid-operation: BUS_RST_N low for 1 cycle during WAIT_LOCK of stage 2.
  - Required: next cycle, all outputs are at their reset values.
